// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one full-subtractor cell, LSB first.
// Latency: start accepted at edge k, done high in the cycle after edge k+WIDTH.
// Backpressure: start is ignored while busy; no queuing.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             br;
   logic [CW-1:0]    cnt;
   logic             ai, bi, di, br_nxt, last, accept;

   assign ai     = a_sh[0];
   assign bi     = b_sh[0];
   assign di     = ai ^ bi ^ br;
   assign br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
   assign last   = (cnt == CW'(WIDTH - 1));
   assign accept = (state == IDLE) && start;

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = SHIFT;
         SHIFT: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         br   <= 1'b0;
         cnt  <= '0;
         d    <= '0;
         bout <= 1'b0;
         ovf  <= 1'b0;
      end else if (accept) begin
         a_sh <= a;
         b_sh <= b;
         br   <= bin;
         cnt  <= '0;
         d    <= '0;
         bout <= 1'b0;
         ovf  <= 1'b0;
      end else if (state == SHIFT) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         br   <= br_nxt;
         cnt  <= cnt + CW'(1);
         d    <= {di, d[WIDTH-1:1]};
         // On the last shift ai/bi/di are the operand and result sign bits.
         if (last) begin
            bout <= br_nxt;
            ovf  <= (ai ^ bi) & (di ^ ai);
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, exhaustive and random checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         bin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] d;
   logic         bout, ovf, busy, done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .d(d), .bout(bout), .ovf(ovf), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction; ovf by the sign-bit rule on the operands.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                        output logic [W-1:0] ed, output logic eb, output logic eo);
      int diff;
      diff = int'(ma) - int'(mb) - int'(mbin);
      ed   = W'(diff);
      eb   = (diff < 0);
      eo   = (ma[W-1] != mb[W-1]) && (ed[W-1] != ma[W-1]);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         input string tag);
      int c;
      logic [W-1:0] ed;
      logic eb, eo;
      model(ta, tb_v, tbin, ed, eb, eo);
      start = 1'b1; a = ta; b = tb_v; bin = tbin;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      while (!done && c < 20) begin
         a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         @(negedge clk);
         c++;
      end
      chk({tag, " latency"}, c, W + 1);
      chk({tag, " d"}, 32'(d), 32'(ed));
      chk({tag, " bout"}, 32'(bout), 32'(eb));
      chk({tag, " ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      chk({tag, " done_pulse"}, 32'(done), 32'd0);
      chk({tag, " busy_fall"}, 32'(busy), 32'd0);
      chk({tag, " d_hold"}, 32'(d), 32'(ed));
   endtask

   initial begin
      int npulse;
      logic [W-1:0] dseen;
      logic prev_done;

      // Reset state
      #12;
      chk("rst d", 32'(d), 32'd0);
      chk("rst bout", 32'(bout), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op(4'd5, 4'd3, 1'b0, "t1");
      run_op(4'd3, 4'd5, 1'b0, "t2");
      run_op(4'd0, 4'd0, 1'b1, "t3");
      run_op(4'b0111, 4'b1000, 1'b0, "t4a");
      run_op(4'b1000, 4'b0001, 1'b0, "t4b");

      // Start while busy is ignored
      start = 1'b1; a = 4'd9; b = 4'd4; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 4'd1; b = 4'd1;
      @(negedge clk);
      start = 1'b0;
      npulse = 0; dseen = '0; prev_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (prev_done) chk("t5 busy_fall", 32'(busy), 32'd0);
         prev_done = done;
         if (done) begin
            npulse++;
            dseen = d;
         end
         @(negedge clk);
      end
      chk("t5 done_count", npulse, 1);
      chk("t5 d", 32'(dseen), 32'd5);

      // Reset mid-operation
      start = 1'b1; a = 4'd9; b = 4'd4; bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6 d", 32'(d), 32'd0);
      chk("t6 bout", 32'(bout), 32'd0);
      chk("t6 ovf", 32'(ovf), 32'd0);
      chk("t6 busy", 32'(busy), 32'd0);
      chk("t6 done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) npulse++;
         @(negedge clk);
      end
      chk("t6 no_done", npulse, 0);
      run_op(4'd15, 4'd15, 1'b0, "t6 fresh");

      // Exhaustive sweep
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            for (int k = 0; k < 2; k++)
               run_op(W'(i), W'(j), 1'(k), "sweep");

      // Random operands with random idle gaps
      for (int n = 0; n < 40; n++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) @(negedge clk);
         run_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
